// File: rtl/rr_req_client.sv
// Requester-side client for an N-way round-robin arbiter: queues jobs as
// saturating per-channel counts, drives req_o, and serves one grant at a time.
module rr_req_client #(
  parameter int N           = 4,
  parameter int CNT_W       = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] push_i,
  input  logic [N-1:0] gnt_i,
  output logic [N-1:0] req_o,
  output logic         busy_o,
  output logic [1:0]   owner_o,
  output logic [N-1:0] done_o,
  output logic         ovf_o,
  output logic         err_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cnt [N];

  logic              gnt_onehot;
  logic [1:0]        gnt_idx;
  logic              accept;
  logic [N-1:0]      dec;

  // Handshake: req_o[i] is a level request; a grant is taken only when it is
  // one-hot, we are IDLE, and the granted channel actually has pending work.
  always_comb begin
    gnt_onehot = (gnt_i != '0) && ((gnt_i & (gnt_i - N'(1))) == '0);
    gnt_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_i[i]) gnt_idx = 2'(i);
    end
    accept = (state == IDLE) && gnt_onehot && (cnt[gnt_idx] != '0);
    dec    = accept ? gnt_i : '0;
  end

  always_comb begin
    req_o = '0;
    for (int i = 0; i < N; i++) begin
      req_o[i] = (state == IDLE) && (cnt[i] != '0);
    end
  end

  assign busy_o = (state == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      owner_o  <= '0;
      done_o   <= '0;
      ovf_o    <= 1'b0;
      err_o    <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      done_o <= '0;

      // Push and accept on the same channel cancel out.
      for (int i = 0; i < N; i++) begin
        if (push_i[i] && !dec[i]) begin
          if (cnt[i] == CNT_MAX) ovf_o <= 1'b1;
          else                   cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (!push_i[i] && dec[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            owner_o  <= gnt_idx;
            hold_cnt <= HOLD_LOAD;
            state    <= BUSY;
          end else if (gnt_i != '0) begin
            err_o <= 1'b1;
          end
        end
        BUSY: begin
          if (gnt_i != '0) err_o <= 1'b1;
          if (hold_cnt == '0) begin
            state  <= IDLE;
            done_o <= N'(1) << owner_o;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
